// File: rtl/mul_taint_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency, taint-tracked multiplier between two requesters.
// Optional feature MUL_TAINT_KILL_EN: a kill input zeroes the result of a tainted in-flight job.
module mul_taint_arbiter #(
    parameter int NUM_BITS = 7,
    parameter int LATENCY  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [NUM_BITS-1:0]   req0_a,
    input  logic [NUM_BITS-1:0]   req0_b,
    input  logic                  req0_t,
    input  logic [NUM_BITS-1:0]   req1_a,
    input  logic [NUM_BITS-1:0]   req1_b,
    input  logic                  req1_t,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [2*NUM_BITS-1:0] rsp_product,
    output logic                  rsp_t,
`ifdef MUL_TAINT_KILL_EN
    input  logic                  kill,
    output logic                  rsp_killed,
`endif
    output logic                  busy,
    output logic                  mul_rst,
    output logic                  mul_start,
    output logic [NUM_BITS-1:0]   mul_multiplier,
    output logic [NUM_BITS-1:0]   mul_multiplicand,
    output logic                  mul_start_t,
    output logic                  mul_multiplier_t,
    output logic                  mul_multiplicand_t,
    input  logic [2*NUM_BITS-1:0] mul_product
);

    localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        RUN,
        RESP
    } state_t;

    state_t              state;
    logic                ptr;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_BITS-1:0] a_lat;
    logic [NUM_BITS-1:0] b_lat;
    logic                t_lat;
    logic                id_lat;
    logic                win_id;
    logic                accept;

    // Operands and taint are presented straight from the job latches, so they stay put through RUN.
    assign mul_multiplier     = a_lat;
    assign mul_multiplicand   = b_lat;
    assign mul_start_t        = t_lat;
    assign mul_multiplier_t   = t_lat;
    assign mul_multiplicand_t = t_lat;

    // Grant looks only at valid bits and the pointer, never at taint or operands.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        win_id    = 1'b0;
        req_ready = 2'b00;
        case (req_valid)
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ptr;
            default: win_id = 1'b0;
        endcase
        accept = rst && (state == IDLE) && (req_valid != 2'b00);
        if (accept) begin
            req_ready = win_id ? 2'b10 : 2'b01;
        end
    end

`ifdef MUL_TAINT_KILL_EN
    logic kill_flag;
    logic kill_hit;

    assign kill_hit = kill && t_lat;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: state and registered outputs use <= so every flop samples the pre-edge values.
            state       <= IDLE;
            ptr         <= 1'b0;
            cnt         <= '0;
            a_lat       <= '0;
            b_lat       <= '0;
            t_lat       <= 1'b0;
            id_lat      <= 1'b0;
            busy        <= 1'b0;
            mul_rst     <= 1'b1;
            mul_start   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
            rsp_t       <= 1'b0;
`ifdef MUL_TAINT_KILL_EN
            kill_flag   <= 1'b0;
            rsp_killed  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mul_rst <= 1'b0;
                    if (accept) begin
                        a_lat   <= win_id ? req1_a : req0_a;
                        b_lat   <= win_id ? req1_b : req0_b;
                        t_lat   <= win_id ? req1_t : req0_t;
                        id_lat  <= win_id;
                        ptr     <= ~win_id;
                        busy    <= 1'b1;
                        mul_rst <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    mul_rst   <= 1'b0;
                    mul_start <= 1'b1;
                    state     <= START;
                end
                START: begin
                    mul_start <= 1'b0;
                    cnt       <= '0;
                    state     <= RUN;
`ifdef MUL_TAINT_KILL_EN
                    if (kill_hit) kill_flag <= 1'b1;
`endif
                end
                RUN: begin
`ifdef MUL_TAINT_KILL_EN
                    if (kill_hit) kill_flag <= 1'b1;
`endif
                    if (cnt == CNT_LAST) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= id_lat;
                        rsp_product <= mul_product;
                        rsp_t       <= t_lat;
`ifdef MUL_TAINT_KILL_EN
                        // A kill on the capture edge itself still counts.
                        if (kill_flag || kill_hit) begin
                            rsp_product <= '0;
                            rsp_t       <= 1'b1;
                            rsp_killed  <= 1'b1;
                        end
`endif
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
`ifdef MUL_TAINT_KILL_EN
                        kill_flag  <= 1'b0;
                        rsp_killed <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
